// File: rtl/count_sched.sv
// Round-robin scheduler sharing one W-bit up-counter between two requesters.
// Optional pause input is compiled in when COUNT_SCHED_PAUSE_EN is defined.
module count_sched #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [1:0]   req,
  input  logic [W-1:0] tgt0,
  input  logic [W-1:0] tgt1,
`ifdef COUNT_SCHED_PAUSE_EN
  input  logic         pause,
`endif
  output logic [1:0]   gnt,
  output logic [W-1:0] Q,
  output logic         upper,
  output logic [1:0]   done,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t       state_reg, state_next;
  logic [W-1:0] q_reg, q_next;
  logic [W-1:0] tgt_reg, tgt_next;
  logic [1:0]   gnt_reg, gnt_next;
  logic [1:0]   done_reg, done_next;
  logic         last_reg, last_next;
  logic         owner;
  logic         pick;
  logic         pause_i;

`ifdef COUNT_SCHED_PAUSE_EN
  assign pause_i = pause;
`else
  assign pause_i = 1'b0;
`endif

  // gnt is one-hot while busy, so its upper bit names the owner
  assign owner = gnt_reg[1];
  // On a tie the requester that was not served last wins
  assign pick  = (req == 2'b11) ? ~last_reg : req[1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      q_reg     <= '0;
      tgt_reg   <= '0;
      gnt_reg   <= 2'b00;
      done_reg  <= 2'b00;
      last_reg  <= 1'b1;
    end else begin
      state_reg <= state_next;
      q_reg     <= q_next;
      tgt_reg   <= tgt_next;
      gnt_reg   <= gnt_next;
      done_reg  <= done_next;
      last_reg  <= last_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE: if (req != 2'b00) state_next = RUN;
      RUN: begin
        if (!req[owner])            state_next = IDLE;
        else if (pause_i)           state_next = RUN;
        else if (q_reg == tgt_reg)  state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    q_next    = q_reg;
    tgt_next  = tgt_reg;
    gnt_next  = gnt_reg;
    done_next = 2'b00;
    last_next = last_reg;
    unique case (state_reg)
      IDLE: begin
        q_next = '0;
        if (req != 2'b00) begin
          gnt_next = pick ? 2'b10 : 2'b01;
          tgt_next = pick ? tgt1 : tgt0;
        end
      end
      RUN: begin
        if (!req[owner]) begin
          // Owner withdrew: release without a completion pulse
          q_next    = '0;
          gnt_next  = 2'b00;
          last_next = owner;
        end else if (pause_i) begin
          q_next = q_reg;
        end else if (q_reg == tgt_reg) begin
          done_next = gnt_reg;
        end else begin
          q_next = q_reg + 1'b1;
        end
      end
      DONE: begin
        q_next    = '0;
        gnt_next  = 2'b00;
        last_next = owner;
      end
      default: begin
        q_next   = '0;
        gnt_next = 2'b00;
      end
    endcase
  end

  assign gnt   = gnt_reg;
  assign Q     = q_reg;
  assign upper = q_reg[W-1];
  assign done  = done_reg;
  assign busy  = (state_reg != IDLE);

endmodule

// File: tb/tb_count_sched.sv
// Bench for count_sched: directed scenarios plus randomized traffic checked
// every cycle against a burst-timeline model (elapsed cycles since grant).
module tb_count_sched;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [1:0]   req = 2'b00;
  logic [W-1:0] tgt0 = '0;
  logic [W-1:0] tgt1 = '0;
  logic         pause_m = 1'b0;
  logic [1:0]   gnt, done;
  logic [W-1:0] Q;
  logic         upper, busy;

  int checks = 0;
  int errors = 0;

  int qs[5] = '{1, 2, 3, 3, 0};
  int ds[5] = '{0, 0, 0, 1, 0};

  always #5 clk = ~clk;

  count_sched #(.W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .tgt0  (tgt0),
    .tgt1  (tgt1),
`ifdef COUNT_SCHED_PAUSE_EN
    .pause (pause_m),
`endif
    .gnt   (gnt),
    .Q     (Q),
    .upper (upper),
    .done  (done),
    .busy  (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, want, $time);
    end
  endtask

  // Model: a burst is (owner, target t, elapsed el). Q = min(el,t),
  // done when el == t+1, burst over when el reaches t+2.
  bit m_act = 1'b0;
  bit m_own = 1'b0;
  bit m_last = 1'b1;
  int m_t = 0;
  int m_el = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_act  = 1'b0;
      m_last = 1'b1;
      m_el   = 0;
    end else if (!m_act) begin
      if (req != 2'b00) begin
        m_own = (req == 2'b11) ? !m_last : req[1];
        m_t   = m_own ? int'(tgt1) : int'(tgt0);
        m_el  = 0;
        m_act = 1'b1;
      end
    end else if (m_el <= m_t && !req[m_own]) begin
      m_act  = 1'b0;
      m_last = m_own;
    end else if (!(m_el <= m_t && pause_m)) begin
      m_el++;
      if (m_el == m_t + 2) begin
        m_act  = 1'b0;
        m_last = m_own;
      end
    end
  end

  always @(negedge clk) begin
    logic [1:0]   eg;
    logic [1:0]   ed;
    logic [W-1:0] eq;
    eg = m_act ? (m_own ? 2'b10 : 2'b01) : 2'b00;
    eq = m_act ? W'((m_el < m_t) ? m_el : m_t) : '0;
    ed = (m_act && m_el == m_t + 1) ? eg : 2'b00;
    chk("model_gnt", gnt, eg);
    chk("model_q", Q, eq);
    chk("model_done", done, ed);
    chk("model_busy", busy, m_act);
    chk("model_upper", upper, eq[W-1]);
  end

  initial begin
    int gcount, dcount, maxq, n, zeros, found, k;
    logic [1:0] prev;
    logic [1:0] gs[3];
    int gaps[3];

    // Reset with both requests pending
    reset = 1'b0; req = 2'b11; tgt0 = 4'd3;
    repeat (2) @(negedge clk);
    chk("rst_gnt", gnt, 0); chk("rst_q", Q, 0);
    chk("rst_done", done, 0); chk("rst_busy", busy, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("first_gnt", gnt, 2'b01); chk("first_q", Q, 0);

    // Single burst, target 3
    req = 2'b01;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("burst_q", Q, qs[i]);
      chk("burst_done", done, ds[i]);
      chk("burst_upper", upper, 0);
      if (done[0]) req = 2'b00;
    end

    // Full range on requester 1
    req = 2'b10; tgt1 = 4'd15;
    gcount = 0; dcount = 0; maxq = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (gnt == 2'b10) gcount++;
      if (int'(Q) > maxq) maxq = int'(Q);
      chk("full_upper", upper, (Q >= 4'd8));
      if (done == 2'b10) begin dcount++; req = 2'b00; end
    end
    chk("full_gnt_cycles", gcount, 17);
    chk("full_done_count", dcount, 1);
    chk("full_max_q", maxq, 15);

    // Round robin with both requests held
    req = 2'b11; tgt0 = 4'd1; tgt1 = 4'd2;
    prev = 2'b00; n = 0; zeros = 0;
    for (int i = 0; i < 60 && n < 3; i++) begin
      @(negedge clk);
      if (gnt != 2'b00 && prev == 2'b00) begin
        gs[n] = gnt; gaps[n] = zeros; n++;
      end
      if (done != 2'b00) chk("rr_done_owner", done, gnt);
      zeros = (gnt == 2'b00) ? zeros + 1 : 0;
      prev = gnt;
    end
    chk("rr_grants", n, 3);
    chk("rr_g0", gs[0], 2'b01); chk("rr_g1", gs[1], 2'b10); chk("rr_g2", gs[2], 2'b01);
    chk("rr_gap1", gaps[1], 1); chk("rr_gap2", gaps[2], 1);
    req = 2'b00;
    repeat (3) @(negedge clk);

    // Abort at Q=4, then tie goes to requester 1
    req = 2'b01; tgt0 = 4'd9; found = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (gnt == 2'b01 && Q == 4'd4) begin found = 1; break; end
    end
    chk("abort_reach", found, 1);
    req = 2'b00;
    @(negedge clk);
    chk("abort_gnt", gnt, 0); chk("abort_q", Q, 0);
    chk("abort_done", done, 0); chk("abort_busy", busy, 0);
    req = 2'b11; tgt1 = 4'd12;
    @(negedge clk);
    chk("abort_regrant", gnt, 2'b10);

    // Asynchronous reset mid-count at Q=6
    found = 0;
    for (int i = 0; i < 30; i++) begin
      if (gnt == 2'b10 && Q == 4'd6) begin found = 1; break; end
      @(negedge clk);
    end
    chk("async_reach", found, 1);
    #2 reset = 1'b0;
    #1;
    chk("async_q", Q, 0); chk("async_gnt", gnt, 0); chk("async_busy", busy, 0);
    @(negedge clk);
    req = 2'b00; reset = 1'b1;
    repeat (2) @(negedge clk);

`ifdef COUNT_SCHED_PAUSE_EN
    // Three pause cycles at Q=2 delay completion by three cycles
    req = 2'b01; tgt0 = 4'd4; found = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (gnt == 2'b01 && Q == 4'd2) begin found = 1; break; end
    end
    chk("pause_reach", found, 1);
    pause_m = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("pause_hold_q", Q, 2);
    end
    pause_m = 1'b0; k = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      k++;
      if (done == 2'b01) break;
    end
    chk("pause_done_delay", k, 3);
    req = 2'b00;
    repeat (2) @(negedge clk);
`endif

    // Randomized traffic, aborts, pauses and occasional resets
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (req[i] && done[i]) req[i] = 1'b0;
        else if (req[i] && $urandom_range(0, 99) < 2) req[i] = 1'b0;
        else if (!req[i] && $urandom_range(0, 99) < 30) req[i] = 1'b1;
      end
      tgt0 = W'($urandom_range(0, ($urandom_range(0, 3) == 0) ? 15 : 4));
      tgt1 = W'($urandom_range(0, ($urandom_range(0, 3) == 0) ? 15 : 4));
`ifdef COUNT_SCHED_PAUSE_EN
      pause_m = ($urandom_range(0, 9) == 0);
`endif
      reset = ($urandom_range(0, 999) < 3) ? 1'b0 : 1'b1;
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/count_sched.md
# count_sched

Round-robin controller that shares one W-bit up-counter between two requesters. A granted requester supplies a terminal count; the block clears the counter, steps it once per clock up to that value, pulses `done` to the owner, then releases the counter. It sits in front of the lab counter datapath and replaces free-running counting with scheduled, bounded count bursts. `upper` keeps its meaning as the counter MSB.

## Interface
- `W`, 4, counter and target width (≥2)
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low reset
- `req`  in  2  level requests; bit i held high by requester i until `done[i]`
- `tgt0`  in  W  terminal count for requester 0, sampled on the grant edge only
- `tgt1`  in  W  terminal count for requester 1, sampled on the grant edge only
- `pause`  in  1  hold count; present only with `COUNT_SCHED_PAUSE_EN`
- `gnt`  out  2  one-hot grant, or 0 when idle; registered
- `Q`  out  W  counter value; registered
- `upper`  out  1  `Q[W-1]`, combinational from `Q`
- `done`  out  2  one-cycle completion pulse to the owner; registered
- `busy`  out  1  high in RUN and DONE

## Operation
- States are IDLE, RUN and DONE. A 1-bit `last` pointer records the most recently served requester.
- Reset (`reset`=0, asynchronous) forces:
  - state to IDLE;
  - `Q`=0, `gnt`=0, `done`=0, `busy`=0;
  - `last`=1, so requester 0 wins the first tie.
- IDLE:
  - With `req`≠0: grant the single requester, or on a tie grant the one ≠ `last`.
  - On that grant edge: `gnt` is set, the owner's target is latched into internal `tgt_q`, `Q`←0, and the state goes to RUN.
  - With `req`=0: hold, with `Q`=0.
- RUN, evaluated each edge in this priority order:
  1. `req[owner]`=0: abort. Go to IDLE, `Q`←0, `gnt`←0, `last`←owner, and no `done` pulse.
  2. `pause`=1 (macro builds only): hold `Q` and state.
  3. `Q`==`tgt_q`: go to DONE with `Q` held and `done[owner]`←1.
  4. Otherwise `Q`←`Q`+1.
- DONE lasts exactly one cycle, with `done[owner]`=1 and `gnt` still high. The next edge:
  - goes to IDLE with `Q`←0, `gnt`←0, `done`←0, `last`←owner;
  - `req` is ignored during DONE.
- Arithmetic: `Q` never exceeds `tgt_q` ≤ 2^W−1, so it never wraps. `tgt_q` is unaffected by later changes to `tgt0`/`tgt1`.
- Simultaneous events:
  - A request from the non-owner during RUN/DONE waits. It is granted on the first IDLE edge.
  - Both requests held continuously alternate service 0,1,0,1…

## Timing
- Request to grant: `req` high before edge k gives `gnt` high after edge k (latency 1), with `Q`=0.
- Target T, no pause:
  - `Q` steps 0…T on edges k..k+T;
  - DONE is entered at edge k+T+1;
  - `done` is high for the cycle after edge k+T+1;
  - IDLE is entered at edge k+T+2.
- `gnt` is high for T+2 cycles.
- There is a minimum of one IDLE cycle between consecutive grants, so a new grant comes no earlier than edge k+T+3.
- T=0: one RUN cycle with `Q`=0, then DONE.
- Each `pause` cycle in RUN extends every later event by one cycle.
- Reset deassertion takes effect at the first `clk` edge after `reset` rises; no outputs glitch.

## Configuration
- `COUNT_SCHED_PAUSE_EN` defined:
  - the `pause` port exists;
  - `pause`=1 in RUN freezes `Q`, suppresses the terminal check and holds the state;
  - `pause` is ignored in IDLE and DONE.
- `COUNT_SCHED_PAUSE_EN` undefined:
  - no `pause` port;
  - behaviour is identical to `pause`=0 at all times.

## Test plan
- Reset: hold `reset`=0 for 2 cycles with `req`=2'b11 → `Q`=0, `gnt`=0, `done`=0, `busy`=0. Release, then after the first edge `gnt`=2'b01.
- Single burst: `req`=01, `tgt0`=3 → `Q` sequence 0,1,2,3,3,0; `done`=01 for exactly one cycle, coinciding with the second `Q`=3; `upper`=0 throughout.
- Full range with W=4: `req`=10, `tgt1`=15 → `Q` counts 0..15 with no wrap; `upper`=1 while `Q`≥8; `done`=10 once; `gnt` is high for 17 cycles.
- Round robin: `req`=11 held, `tgt0`=1, `tgt1`=2 → grants alternate 01,10,01; each grant is preceded by exactly one IDLE cycle; the `done` pulses alternate to match.
- Abort and async reset:
  - `req`=01, `tgt0`=9: drop `req[0]` while `Q`=4 → IDLE next edge, `Q`=0, no `done`. Then raise `req`=11 → grant 10, since `last`=0.
  - Separately, pull `reset` low mid-count with `Q`=6 → `Q`=0 and `gnt`=0 immediately, without waiting for a clock edge.
- Pause (macro builds only): `tgt0`=4, `pause`=1 for 3 cycles while `Q`=2 → `Q` holds at 2 for those 3 cycles; the `done` pulse is delayed by exactly 3 cycles.
